// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : Multicycle control FSM for the shared-memory MIPS datapath
//               (single memory port, IR/ALUOut registers). Sequences fetch /
//               decode / execute / memory / writeback for RTYPE, LW, SW, BEQ,
//               BNE, ADDI, ANDI, ORI, XORI and J, and handshakes with the
//               unified memory through mem_req / mem_ready.
// Parameters  : TIMEOUT  cycles a memory state waits for mem_ready before
//                        flagging bus_err (1..255); 0 disables the timeout.
// Build macro : MC_TRAP_EN  when defined, illegal op/funct or a memory
//               timeout enters the sticky TRAP state (trap=1, everything else
//               0, until reset). When undefined those events return to FETCH
//               and trap is tied 0.
// Ports       : clk, reset (async, active-high)
//               op, funct, zero, mem_ready             - datapath/memory status
//               mem_req, memwrite, iord, irwrite, pcen - memory/PC/IR control
//               pcsrc, alusrca, alusrcb, alucontrol    - ALU/PC muxing
//               regdst, memtoreg, regwrite             - register-file control
//               bus_err, trap, state                   - error and debug
// Revision    : 1.0  initial release
// ============================================================================
module mc_sequencer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       bus_err,
   output logic       trap,
   output logic [3:0] state
);

   // State encoding (visible on the debug state port)
   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_MEMADR = 4'd2;
   localparam logic [3:0] ST_MEMRD  = 4'd3;
   localparam logic [3:0] ST_MEMWB  = 4'd4;
   localparam logic [3:0] ST_MEMWR  = 4'd5;
   localparam logic [3:0] ST_EXEC   = 4'd6;
   localparam logic [3:0] ST_ALUWB  = 4'd7;
   localparam logic [3:0] ST_BRANCH = 4'd8;
   localparam logic [3:0] ST_IEXEC  = 4'd9;
   localparam logic [3:0] ST_IWB    = 4'd10;
   localparam logic [3:0] ST_JUMP   = 4'd11;
   localparam logic [3:0] ST_TRAP   = 4'd12;

   // Where illegal instructions and memory timeouts go
`ifdef MC_TRAP_EN
   localparam logic [3:0] ST_ERR = ST_TRAP;
`else
   localparam logic [3:0] ST_ERR = ST_FETCH;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Last wait count before timeout fires (only meaningful when TIMEOUT != 0)
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [3:0] state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   logic       mem_state;
   logic       timeout_hit;
   logic       funct_ok;
   logic [2:0] funct_alu;
   logic [2:0] imm_alu;

   // ---------------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------------
   always_comb begin
      mem_state   = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
      // mem_ready in the same cycle takes priority over the timeout
      timeout_hit = mem_state && !mem_ready && (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);
   end

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_AND;
      case (funct)
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b100000: funct_alu = ALU_ADD;
         6'b000100: funct_alu = ALU_SLL;
         6'b000110: funct_alu = ALU_SRL;
         6'b100110: funct_alu = ALU_XOR;
         6'b100010: funct_alu = ALU_SUB;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         OP_ANDI: imm_alu = ALU_AND;
         OP_ORI:  imm_alu = ALU_OR;
         OP_XORI: imm_alu = ALU_XOR;
         default: imm_alu = ALU_ADD;
      endcase
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready)        state_d = ST_DECODE;
            else if (timeout_hit) state_d = ST_ERR;
         end
         ST_DECODE: begin
            case (op)
               OP_LW, OP_SW:                       state_d = ST_MEMADR;
               OP_RTYPE:                           state_d = ST_EXEC;
               OP_BEQ, OP_BNE:                     state_d = ST_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI:  state_d = ST_IEXEC;
               OP_J:                               state_d = ST_JUMP;
               default:                            state_d = ST_ERR;
            endcase
         end
         ST_MEMADR: state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD: begin
            if (mem_ready)        state_d = ST_MEMWB;
            else if (timeout_hit) state_d = ST_ERR;
         end
         ST_MEMWR: begin
            if (mem_ready)        state_d = ST_FETCH;
            else if (timeout_hit) state_d = ST_ERR;
         end
         ST_EXEC:   state_d = funct_ok ? ST_ALUWB : ST_ERR;
         ST_IEXEC:  state_d = ST_IWB;
         ST_MEMWB, ST_ALUWB, ST_IWB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
         // Sticky when trapping is enabled; otherwise unreachable
         ST_TRAP:   state_d = ST_ERR;
         default:   state_d = ST_FETCH;
      endcase

      // Counts only while a memory state is still waiting; any exit, ready,
      // timeout (including FETCH->FETCH refetch) or non-memory state clears it.
      if (mem_state && !mem_ready && !timeout_hit)
         wait_cnt_d = wait_cnt_q + 8'd1;
      else
         wait_cnt_d = 8'd0;
   end

   // ---------------------------------------------------------------------
   // Output logic (Moore, with mem_ready/zero qualifiers where noted).
   // Everything is forced low while reset is asserted, so an in-flight
   // memory access is abandoned immediately.
   // ---------------------------------------------------------------------
   always_comb begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = ALU_AND;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      bus_err    = 1'b0;
      trap       = 1'b0;
      state      = 4'd0;
      if (!reset) begin
         state = state_q;
         case (state_q)
            ST_FETCH: begin
               mem_req    = 1'b1;
               alusrcb    = 2'b01;
               alucontrol = ALU_ADD;
               irwrite    = mem_ready;
               pcen       = mem_ready;
               bus_err    = timeout_hit;
            end
            ST_DECODE: begin
               alusrcb    = 2'b11;
               alucontrol = ALU_ADD;
            end
            ST_MEMADR: begin
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               alucontrol = ALU_ADD;
            end
            ST_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               bus_err = timeout_hit;
            end
            ST_MEMWB: begin
               memtoreg = 1'b1;
               regwrite = 1'b1;
            end
            ST_MEMWR: begin
               mem_req  = 1'b1;
               memwrite = 1'b1;
               iord     = 1'b1;
               bus_err  = timeout_hit;
            end
            ST_EXEC: begin
               alusrca    = 1'b1;
               alucontrol = funct_alu;
            end
            ST_ALUWB: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
            end
            ST_BRANCH: begin
               alusrca    = 1'b1;
               alucontrol = ALU_SUB;
               pcsrc      = 2'b01;
               pcen       = (op == OP_BEQ) ? zero : !zero;
            end
            ST_IEXEC: begin
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               alucontrol = imm_alu;
            end
            ST_IWB: begin
               regwrite = 1'b1;
            end
            ST_JUMP: begin
               pcsrc = 2'b10;
               pcen  = 1'b1;
            end
`ifdef MC_TRAP_EN
            ST_TRAP: trap = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_sequencer
// Description : Directed self-checking bench for mc_sequencer (TIMEOUT=4).
//               Inputs change just after the falling edge; outputs are
//               sampled 1 ns later, well away from the rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mc_sequencer;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       pcen;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alucontrol;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       bus_err;
   logic       trap;
   logic [3:0] state;

   int tests_run;
   int tests_failed;

   mc_sequencer #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .memwrite   (memwrite),
      .iord       (iord),
      .irwrite    (irwrite),
      .pcen       (pcen),
      .pcsrc      (pcsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .bus_err    (bus_err),
      .trap       (trap),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: step past the next falling edge, drive mem_ready, settle.
   task automatic cyc(input logic rdy);
      @(negedge clk);
      mem_ready = rdy;
      #1;
   endtask

   // Pulse reset for one full cycle; comes back out in FETCH.
   task automatic do_reset(input logic rdy);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = rdy;
      #1;
   endtask

   logic [3:0] lw_st  [8];
   logic       lw_rdy [8];
   int         lw_rd_req;
   int         lw_wb;
   int         lw_berr;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      op           = OP_ADDI;
      funct        = 6'd0;
      zero         = 1'b0;
      mem_ready    = 1'b0;

      // ---- reset: everything low even with mem_ready asserted ----
      repeat (2) @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_irwrite", irwrite, 0);
      check("rst_pcen",    pcen,    0);
      check("rst_alusrcb", alusrcb, 0);
      check("rst_state",   state,   0);

      // ---- ADDI, zero-wait memory: FETCH, DECODE, IEXEC, IWB ----
      reset = 1'b0;
      #1;
      check("addi_f_state",   state,      0);
      check("addi_f_irwrite", irwrite,    1);
      check("addi_f_pcen",    pcen,       1);
      check("addi_f_alusrcb", alusrcb,    1);
      check("addi_f_alu",     alucontrol, 3'b010);
      check("addi_f_regw",    regwrite,   0);
      cyc(1'b0);
      check("addi_d_state",   state,      1);
      check("addi_d_alusrcb", alusrcb,    3);
      check("addi_d_regw",    regwrite,   0);
      cyc(1'b0);
      check("addi_e_state",   state,      9);
      check("addi_e_alu",     alucontrol, 3'b010);
      check("addi_e_alusrca", alusrca,    1);
      check("addi_e_alusrcb", alusrcb,    2);
      check("addi_e_regw",    regwrite,   0);
      cyc(1'b0);
      check("addi_wb_state",  state,      10);
      check("addi_wb_regw",   regwrite,   1);
      check("addi_wb_regdst", regdst,     0);

      // ---- LW with 3 wait cycles in MEMRD: 8 cycles total ----
      lw_st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
      lw_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      lw_rd_req = 0;
      lw_wb     = 0;
      lw_berr   = 0;
      op = OP_LW;
      for (int i = 0; i < 8; i++) begin
         cyc(lw_rdy[i]);
         check($sformatf("lw_state_%0d", i), state, lw_st[i]);
         if (mem_req && iord) lw_rd_req++;
         if (regwrite && memtoreg) lw_wb++;
         if (bus_err) lw_berr++;
      end
      check("lw_rd_req_cycles", 8'(lw_rd_req), 4);
      check("lw_memwb_cycles",  8'(lw_wb),     1);
      check("lw_no_bus_err",    8'(lw_berr),   0);

      // ---- BNE not-equal (zero=0): taken ----
      op   = OP_BNE;
      zero = 1'b0;
      cyc(1'b1);
      check("lw_back_to_fetch", state, 0);
      cyc(1'b0);
      cyc(1'b0);
      check("bne_state", state,      8);
      check("bne_pcen",  pcen,       1);
      check("bne_pcsrc", pcsrc,      1);
      check("bne_alu",   alucontrol, 3'b110);

      // ---- BEQ: not taken with zero=0, taken with zero=1 ----
      op = OP_BEQ;
      cyc(1'b1);
      check("bne_to_fetch", state, 0);
      cyc(1'b0);
      cyc(1'b0);
      check("beq_state", state, 8);
      check("beq_z0_pcen", pcen, 0);
      zero = 1'b1;
      #1;
      check("beq_z1_pcen", pcen, 1);

      // ---- XORI ----
      op   = OP_XORI;
      zero = 1'b0;
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      check("xori_state", state,      9);
      check("xori_alu",   alucontrol, 3'b101);
      cyc(1'b0);

      // ---- R-type SUB ----
      op    = OP_RTYPE;
      funct = 6'b100010;
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      check("sub_state",   state,      6);
      check("sub_alu",     alucontrol, 3'b110);
      check("sub_alusrca", alusrca,    1);
      check("sub_alusrcb", alusrcb,    0);
      cyc(1'b0);
      check("sub_wb_state",  state,    7);
      check("sub_wb_regdst", regdst,   1);
      check("sub_wb_regw",   regwrite, 1);

      // ---- J ----
      op = OP_J;
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      check("j_state", state, 11);
      check("j_pcsrc", pcsrc, 2);
      check("j_pcen",  pcen,  1);

      // ---- Timeout in FETCH with mem_ready stuck low (TIMEOUT=4) ----
      op = OP_ADDI;
      cyc(1'b0);
      check("to_w1_state",   state,   0);
      check("to_w1_mem_req", mem_req, 1);
      check("to_w1_bus_err", bus_err, 0);
      cyc(1'b0);
      cyc(1'b0);
      check("to_w3_bus_err", bus_err, 0);
      cyc(1'b0);
      check("to_w4_bus_err", bus_err, 1);
      check("to_w4_irwrite", irwrite, 0);
      cyc(1'b0);
      check("to_w5_bus_err", bus_err, 0);
`ifdef MC_TRAP_EN
      check("to_trap_state",   state,   12);
      check("to_trap",         trap,    1);
      check("to_trap_mem_req", mem_req, 0);
      cyc(1'b1);
      check("to_trap_sticky",  trap,    1);
      check("to_trap_st_hold", state,   12);
`else
      check("to_refetch_state",   state,   0);
      check("to_refetch_mem_req", mem_req, 1);
      cyc(1'b0);
      check("to_refetch_no_err",  bus_err, 0);
`endif
      do_reset(1'b1);

      // ---- Illegal opcode ----
      op = 6'b111111;
      check("ill_f_state", state, 0);
      cyc(1'b0);
      check("ill_d_state", state, 1);
      cyc(1'b1);
      check("ill_regw",  regwrite, 0);
      check("ill_memw",  memwrite, 0);
`ifdef MC_TRAP_EN
      check("ill_trap_state", state,   12);
      check("ill_trap",       trap,    1);
      check("ill_mem_req",    mem_req, 0);
      cyc(1'b1);
      check("ill_trap_sticky", trap,   1);
      check("ill_trap_pcen",   pcen,   0);
`else
      check("ill_fetch_state", state,   0);
      check("ill_mem_req",     mem_req, 1);
      check("ill_trap_tied",   trap,    0);
`endif
      do_reset(1'b1);

      // ---- Reset during a MEMWR wait ----
      op = OP_SW;
      cyc(1'b0);
      cyc(1'b0);
      check("sw_adr_state",   state,   2);
      check("sw_adr_alusrcb", alusrcb, 2);
      cyc(1'b0);
      check("sw_wr_state",    state,    5);
      check("sw_wr_mem_req",  mem_req,  1);
      check("sw_wr_memwrite", memwrite, 1);
      check("sw_wr_iord",     iord,     1);
      reset = 1'b1;
      #1;
      check("sw_rst_mem_req",  mem_req,  0);
      check("sw_rst_memwrite", memwrite, 0);
      check("sw_rst_state",    state,    0);
      cyc(1'b0);
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("sw_post_state",    state,    0);
      check("sw_post_mem_req",  mem_req,  1);
      check("sw_post_memwrite", memwrite, 0);
      check("sw_post_trap",     trap,     0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
